// File: rtl/router_rx_pkg.sv
// Shared types for the per-port serial receiver: FSM state encoding,
// the FIFO entry layout and the address width.
package router_rx_pkg;

  localparam int ADDR_BITS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    PAD   = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// Synchronous FIFO of rx_entry_t. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter. A push into
// a full FIFO is accepted only when a pop happens in the same cycle.
module router_rx_fifo
  import router_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push_i,
  input  rx_entry_t push_data_i,
  output logic      full_o,
  input  logic      pop_i,
  output rx_entry_t pop_data_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  rx_entry_t   r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign empty_o    = (r_wr_ptr == r_rd_ptr);
  assign full_o     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop_ok   = pop_i && !empty_o;
  assign w_push_ok  = push_i && (!full_o || w_pop_ok);
  assign pop_data_o = r_mem[r_rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// Per-port serial receiver: decodes address, padding and LSB-first payload
// bytes from din/frame_n/valid_n and queues {last, byte} entries.
//
// Output handshake: an entry transfers on a rising clock edge where rx_valid_o
// and rx_ready_i are both high. rx_valid_o never depends on rx_ready_i, and
// rx_data_o/rx_last_o hold their value while rx_valid_o is high and
// rx_ready_i is low.
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int PAD_CYCLES = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 din,
  input  logic                 frame_n,
  input  logic                 valid_n,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 addr_valid_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_last_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 ovf_o
);

  localparam int AIW = $clog2(ADDR_BITS);

  rx_state_e            r_state;
  logic                 r_frame_q;
  logic [7:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr_sh;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_addr_valid;
  logic [7:0]           r_byte_sh;
  logic [2:0]           r_bitcnt;
  logic                 r_push;
  rx_entry_t            r_push_entry;
  logic                 r_err;
  logic                 r_ovf;

  logic [ADDR_BITS-1:0] w_addr_full;
  logic [7:0]           w_byte_full;
  logic                 w_start;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  rx_entry_t            w_head;

  // A packet starts only on a high-to-low frame_n edge seen from IDLE, so a
  // reset in the middle of a packet does not decode its tail.
  assign w_start = (r_state == IDLE) && !frame_n && r_frame_q;
  assign w_pop   = rx_ready_i && !w_empty;

  // Complete address/byte including the bit arriving this cycle
  always_comb begin
    w_addr_full                = r_addr_sh;
    w_addr_full[ADDR_BITS-1]   = din;
    w_byte_full                = r_byte_sh;
    w_byte_full[7]             = din;
  end

  // Protocol FSM with address/payload deserializers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_frame_q    <= 1'b0;
      r_cnt        <= '0;
      r_addr_sh    <= '0;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_byte_sh    <= '0;
      r_bitcnt     <= '0;
      r_push       <= 1'b0;
      r_push_entry <= '0;
      r_err        <= 1'b0;
    end else begin
      r_frame_q    <= frame_n;
      r_addr_valid <= 1'b0;
      r_err        <= 1'b0;
      r_push       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr_sh <= {{(ADDR_BITS-1){1'b0}}, din};
            r_cnt     <= 8'd1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (frame_n) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_addr_sh[r_cnt[AIW-1:0]] <= din;
            if (r_cnt == 8'(ADDR_BITS - 1)) begin
              r_addr       <= w_addr_full;
              r_addr_valid <= 1'b1;
              r_cnt        <= '0;
              r_state      <= PAD;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        PAD: begin
          if (frame_n) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (!valid_n) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= DRAIN;
          end else if (r_cnt == 8'(PAD_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_byte_sh <= '0;
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DATA: begin
          if (!valid_n) begin
            if (r_bitcnt == 3'd7) begin
              r_push       <= 1'b1;
              r_push_entry <= '{last: frame_n, data: w_byte_full};
              r_bitcnt     <= '0;
              r_byte_sh    <= '0;
              if (frame_n) begin
                r_state <= IDLE;
              end
            end else if (frame_n) begin
              // Packet ended mid-byte: the partial byte is discarded
              r_err     <= 1'b1;
              r_bitcnt  <= '0;
              r_byte_sh <= '0;
              r_state   <= IDLE;
            end else begin
              r_byte_sh[r_bitcnt] <= din;
              r_bitcnt            <= r_bitcnt + 3'd1;
            end
          end else if (frame_n) begin
            // Frame closed without a payload bit: treat as a truncated packet
            r_err     <= 1'b1;
            r_bitcnt  <= '0;
            r_byte_sh <= '0;
            r_state   <= IDLE;
          end
        end
        DRAIN: begin
          if (frame_n) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared when a new packet starts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (r_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_start) begin
      r_ovf <= 1'b0;
    end
  end

  router_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (r_push),
    .push_data_i (r_push_entry),
    .full_o      (w_full),
    .pop_i       (rx_ready_i),
    .pop_data_o  (w_head),
    .empty_o     (w_empty)
  );

  assign addr_o       = r_addr;
  assign addr_valid_o = r_addr_valid;
  assign rx_data_o    = w_head.data;
  assign rx_last_o    = w_head.last;
  assign rx_valid_o   = !w_empty;
  assign busy_o       = (r_state != IDLE);
  assign err_o        = r_err;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: scenario tasks drive the serial pins, expected
// entries and addresses are queued as stimulus is driven, and a negedge
// monitor pops and compares them when the DUT presents output.
module tb_router_port_rx;

  localparam int PAD   = 5;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic [3:0] addr_o;
  logic       addr_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_last_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       busy_o;
  logic       err_o;
  logic       ovf_o;

  int checks    = 0;
  int errors    = 0;
  int err_seen  = 0;
  int addr_seen = 0;

  logic [8:0] exp_q[$];
  logic [3:0] exp_addr_q[$];
  logic [7:0] pkt[16];

  logic       prev_stall = 1'b0;
  logic [8:0] prev_entry = '0;
  logic [8:0] m_exp;
  logic [3:0] m_addr;

  router_port_rx #(
    .PAD_CYCLES (PAD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .din          (din),
    .frame_n      (frame_n),
    .valid_n      (valid_n),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .rx_data_o    (rx_data_o),
    .rx_last_o    (rx_last_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .ovf_o        (ovf_o)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard, sampled away from the active edge
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (err_o) err_seen++;
      if (addr_valid_o) begin
        addr_seen++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL addr_unexpected: got addr %h, none expected", addr_o);
        end else begin
          m_addr = exp_addr_q.pop_front();
          if (addr_o !== m_addr) begin
            errors++;
            $display("FAIL addr_value: got %h want %h", addr_o, m_addr);
          end
        end
      end
      if (prev_stall && rx_valid_o) begin
        checks++;
        if ({rx_last_o, rx_data_o} !== prev_entry) begin
          errors++;
          $display("FAIL head_stable: got %h want %h", {rx_last_o, rx_data_o}, prev_entry);
        end
      end
      if (rx_valid_o && rx_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL entry_unexpected: got last=%b data=%h, none expected", rx_last_o, rx_data_o);
        end else begin
          m_exp = exp_q.pop_front();
          if ({rx_last_o, rx_data_o} !== m_exp) begin
            errors++;
            $display("FAIL entry_value: got last=%b data=%h want last=%b data=%h",
                     rx_last_o, rx_data_o, m_exp[8], m_exp[7:0]);
          end
        end
      end
      prev_stall = rx_valid_o && !rx_ready_i;
      prev_entry = {rx_last_o, rx_data_o};
    end
  end

  // Driver tasks
  task automatic drive(input logic f, input logic v, input logic d);
    frame_n = f;
    valid_n = v;
    din     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_header(input logic [3:0] a);
    exp_addr_q.push_back(a);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, a[i]);
    for (int i = 0; i < PAD; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  // Drives pkt[0..nbytes-1]; only the first n_expect bytes are expected out.
  // gap_at: payload bit index preceded by gap_len idle cycles.
  // abort_at: payload bit on which frame_n rises early. stop_at: stop before this bit.
  task automatic send_payload(input int nbytes, input int n_expect, input int gap_at,
                              input int gap_len, input int abort_at, input int stop_at);
    logic f;
    logic d;
    int k;
    int b;
    for (int i = 0; i < nbytes * 8; i++) begin
      if (i == stop_at) return;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end
      k = i / 8;
      b = i % 8;
      d = pkt[k][b];
      if (i == abort_at) begin
        drive(1'b1, 1'b0, d);
        return;
      end
      f = (i == nbytes * 8 - 1);
      drive(f, 1'b0, d);
      if (b == 7 && k < n_expect) exp_q.push_back({f, pkt[k]});
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_valid_o) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rx_valid_o) begin
      errors++;
      $display("FAIL %s_drain: %0d entries still expected, rx_valid_o=%b", name, exp_q.size(), rx_valid_o);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset_n    = 1'b0;
    frame_n    = 1'b1;
    valid_n    = 1'b1;
    din        = 1'b0;
    rx_ready_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    checks++; if (addr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_addr_valid: got %b want 0", addr_valid_o); end
    checks++; if (addr_o !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    checks++; if ({rx_last_o, rx_data_o} !== 9'h000) begin errors++; $display("FAIL reset_head: got %h want 000", {rx_last_o, rx_data_o}); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int e0;
    int a0;
    e0 = err_seen;
    a0 = addr_seen;
    rx_ready_i = 1'b0;
    pkt[0] = 8'hA5;
    send_header(4'hA);
    send_payload(1, 1, -1, 0, -1, -1);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got rx_valid %b want 0", rx_valid_o); end
    idle(1);
    checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL basic_latency: got rx_valid %b want 1", rx_valid_o); end
    checks++; if ({rx_last_o, rx_data_o} !== 9'h1A5) begin errors++; $display("FAIL basic_head: got %h want 1a5", {rx_last_o, rx_data_o}); end
    idle(2);
    rx_ready_i = 1'b1;
    wait_drain("basic");
    checks++; if (err_seen != e0) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", err_seen - e0); end
    checks++; if (addr_seen != a0 + 1) begin errors++; $display("FAIL basic_addr_pulse: got %0d want 1", addr_seen - a0); end
  endtask

  task automatic test_gap();
    int e0;
    e0 = err_seen;
    rx_ready_i = 1'b1;
    pkt[0] = 8'h01;
    pkt[1] = 8'hFF;
    pkt[2] = 8'h3C;
    send_header(4'h5);
    send_payload(3, 3, 12, 3, -1, -1);
    idle(2);
    wait_drain("gap");
    checks++; if (err_seen != e0) begin errors++; $display("FAIL gap_err: got %0d pulses want 0", err_seen - e0); end
  endtask

  task automatic test_overflow();
    rx_ready_i = 1'b0;
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    pkt[3] = 8'h44; pkt[4] = 8'h55; pkt[5] = 8'h66;
    send_header(4'hC);
    send_payload(6, DEPTH, -1, 0, -1, -1);
    idle(2);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_o); end
    checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_rx_valid: got %b want 1", rx_valid_o); end
    rx_ready_i = 1'b1;
    wait_drain("ovf");
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_o); end
    pkt[0] = 8'h5A;
    send_header(4'h3);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf_o); end
    send_payload(1, 1, -1, 0, -1, -1);
    idle(2);
    wait_drain("ovf_next");
  endtask

  task automatic test_frame_abort();
    int e0;
    e0 = err_seen;
    rx_ready_i = 1'b1;
    pkt[0] = 8'hF0;
    send_header(4'h5);
    send_payload(1, 0, -1, 0, 3, -1);
    idle(3);
    checks++; if (err_seen != e0 + 1) begin errors++; $display("FAIL abort_err: got %0d pulses want 1", err_seen - e0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL abort_no_entry: got rx_valid %b want 0", rx_valid_o); end
    pkt[0] = 8'h96;
    send_header(4'h1);
    send_payload(1, 1, -1, 0, -1, -1);
    idle(2);
    wait_drain("abort_next");
    checks++; if (err_seen != e0 + 1) begin errors++; $display("FAIL abort_next_err: got %0d pulses want 1", err_seen - e0); end
  endtask

  task automatic test_pad_error();
    int e0;
    e0 = err_seen;
    rx_ready_i = 1'b1;
    exp_addr_q.push_back(4'h7);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, (i != 3));
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL pad_drain_busy: got %b want 1", busy_o); end
    drive(1'b1, 1'b0, 1'b1);
    idle(3);
    checks++; if (err_seen != e0 + 1) begin errors++; $display("FAIL pad_err: got %0d pulses want 1", err_seen - e0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pad_busy: got %b want 0", busy_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL pad_no_entry: got rx_valid %b want 0", rx_valid_o); end
  endtask

  task automatic test_reset_mid();
    int e0;
    int a0;
    rx_ready_i = 1'b0;
    pkt[0] = 8'h77;
    pkt[1] = 8'hC3;
    send_header(4'h9);
    send_payload(2, 1, -1, 0, -1, 12);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    checks++; if (addr_o !== 4'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", addr_o); end
    checks++; if ({rx_last_o, rx_data_o} !== 9'h000) begin errors++; $display("FAIL rstmid_head: got %h want 000", {rx_last_o, rx_data_o}); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    e0 = err_seen;
    a0 = addr_seen;
    for (int i = 0; i < 14; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_resync: got busy %b want 0", busy_o); end
    drive(1'b1, 1'b0, 1'b0);
    idle(3);
    checks++; if (err_seen != e0 || addr_seen != a0) begin
      errors++;
      $display("FAIL rstmid_quiet: got err %0d addr %0d want 0 0", err_seen - e0, addr_seen - a0);
    end
    rx_ready_i = 1'b1;
    pkt[0] = 8'h3E;
    send_header(4'h6);
    send_payload(1, 1, -1, 0, -1, -1);
    idle(2);
    wait_drain("rstmid_next");
  endtask

  task automatic test_back_to_back();
    int e0;
    int a0;
    e0 = err_seen;
    a0 = addr_seen;
    rx_ready_i = 1'b1;
    pkt[0] = 8'h81;
    send_header(4'hC);
    send_payload(1, 1, -1, 0, -1, -1);
    pkt[0] = 8'h42;
    pkt[1] = 8'h24;
    send_header(4'h6);
    send_payload(2, 2, -1, 0, -1, -1);
    idle(2);
    wait_drain("b2b");
    checks++; if (err_seen != e0) begin errors++; $display("FAIL b2b_err: got %0d pulses want 0", err_seen - e0); end
    checks++; if (addr_seen != a0 + 2) begin errors++; $display("FAIL b2b_addr_pulses: got %0d want 2", addr_seen - a0); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_frame_abort();
    test_pad_error();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL addr_leftover: got %0d pending addresses want 0", exp_addr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_port_rx.md
Name: router_port_rx

Overview:
- Per-port serial receiver for the 16-port router. It is instantiated once per input port, directly downstream of the testbench-driven din/frame_n/valid_n pins.
- Decodes the serial packet protocol: a 4-bit destination address, then padding, then payload bytes.
- Emits the latched address and a byte stream tagged with an end-of-packet bit through a small FIFO with a valid/ready handshake, for the switch fabric to consume.

Parameters:
- PAD_CYCLES, 5, number of padding cycles between the address and the payload.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2 and at least 2.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  1  serial data; LSB first for both address and payload.
- frame_n  input  1  low for the whole packet; goes high on the final payload bit.
- valid_n  input  1  low when din carries a payload bit.
- addr_o  output  4  destination address of the current packet.
- addr_valid_o  output  1  one-cycle pulse when addr_o is updated.
- rx_data_o  output  8  FIFO head byte.
- rx_last_o  output  1  FIFO head byte is the last byte of its packet.
- rx_valid_o  output  1  FIFO not empty.
- rx_ready_i  input  1  consumer accepts the head entry when rx_valid_o and rx_ready_i are both high.
- busy_o  output  1  high while the FSM is not IDLE.
- err_o  output  1  one-cycle pulse on a protocol error.
- ovf_o  output  1  sticky FIFO-overflow flag; cleared when the next packet starts.

Behaviour:
- Reset (async assert, sync deassert by the system): FSM=IDLE; all outputs 0; FIFO empty; shift registers and counters 0.
- FSM states:
  - IDLE: on frame_n==0, capture din as addr bit0, set cnt=1, clear ovf_o, go to ADDR.
  - ADDR: shift din into addr bit[cnt]. At cnt==3:
    - update addr_o;
    - pulse addr_valid_o in the next cycle;
    - go to PAD with cnt=0.
  - PAD: count PAD_CYCLES cycles, then go to DATA. valid_n must stay high. valid_n==0 in PAD -> err_o pulse, go to DRAIN.
  - DATA, valid_n==1: hold; gaps are legal and nothing is sampled.
  - DATA, valid_n==0: sample din into byte bit[bitcnt]. When bitcnt==7, push {last, byte} to the FIFO, where last = frame_n sampled in the same cycle; bitcnt wraps to 0.
  - DATA, valid_n==0 and frame_n==1:
    - bitcnt==7: normal end of packet, go to IDLE;
    - bitcnt!=7: err_o pulse, discard the partial byte, go to IDLE.
  - DRAIN: ignore din and valid_n until frame_n==1, then go to IDLE.
- frame_n==1 while in ADDR or PAD: err_o pulse, go to IDLE, no addr_valid_o.
- A packet with zero payload bytes is not legal; it is caught by the ADDR/PAD frame_n rule above.
- Latency: byte bit7 sampled at edge N -> rx_valid_o high after edge N+1 (FIFO registered).
- IDLE with frame_n==0 in the cycle right after a packet ends is legal. Back-to-back packets need no idle gap.
- FIFO behaviour:
  - push and pop in the same cycle when full: both succeed, count unchanged;
  - push when full without pop: byte dropped, ovf_o set, FSM continues;
  - pop when empty: ignored;
  - pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit; full when the indices are equal and the wrap bits differ.
- rx_data_o and rx_last_o must be stable while rx_valid_o==1 and rx_ready_i==0.
- Reset mid-packet: return immediately to the reset state; the remainder of the packet is not decoded. The FSM resyncs only on a frame_n high-to-low edge seen from IDLE after frame_n was 1.

Decomposition:
- Package router_rx_pkg holds:
  - typedef enum of the states: IDLE, ADDR, PAD, DATA, DRAIN;
  - typedef struct packed {logic last; logic [7:0] data;} rx_entry_t;
  - localparam ADDR_BITS=4.
- Sub-module router_rx_fifo: a synchronous FIFO of rx_entry_t, parameterised by depth, with push/full and pop/empty. The FSM and deserializer live in router_port_rx.

Test Plan:
- Address 4'hA (din bits 0,1,0,1), 5 pad cycles, payload 8'hA5 with frame_n high on bit 7 -> addr_valid_o pulse with addr_o=A; one entry {last=1, data=A5}; busy_o falls; err_o never asserts.
- Payload 8'h01, 8'hFF, 8'h3C with a 3-cycle valid_n gap mid-byte and rx_ready_i held 1 -> entries 01/0, FF/0, 3C/1 in that order.
- rx_ready_i=0, 6-byte packet with FIFO_DEPTH=4:
  - rx_valid_o stays high;
  - ovf_o=1 after byte 5;
  - draining yields the first 4 bytes only;
  - the next packet clears ovf_o.
- frame_n rises on payload bit 3 -> err_o pulse, no entry pushed, FSM in IDLE; the following good packet decodes correctly.
- valid_n low during pad cycle 2 -> err_o pulse; all bits ignored until frame_n=1; no entries pushed.
- reset_n pulsed low mid-byte -> all outputs 0 and FIFO empty immediately; the next full packet decodes correctly.
